// File: rtl/sqrt_pipe_ctrl.sv
// sqrt_pipe_ctrl: elastic valid/ready controller driving the square-root pipeline stage enables.
// Optional flush port is enabled by defining SQRT_PIPE_FLUSH_EN.
module sqrt_pipe_ctrl #(
   parameter int STAGES = 5,
   parameter int CNT_W  = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [STAGES-1:0]           stage_en,
   output logic [STAGES-1:0]           stage_valid,
   output logic [$clog2(STAGES+1)-1:0] occupancy,
   output logic [CNT_W-1:0]            done_count,
   output logic [1:0]                  state
`ifdef SQRT_PIPE_FLUSH_EN
   ,
   input  logic                        flush
`endif
);
   localparam int OW = $clog2(STAGES+1);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STALL = 2'b10} state_e;
   logic [STAGES-1:0] v_q, v_d, rdy, src;
   logic [OW-1:0]     occ_q, occ_d;
   logic [CNT_W-1:0]  done_q, done_d;
   state_e            state_q, state_d;
   logic              flush_i, kill, accept, emit;
`ifdef SQRT_PIPE_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif
   assign kill = reset | flush_i;
   // ready ripples from the consumer back to the input; a stage loads only live data
   always_comb begin
      rdy = '0;
      rdy[STAGES-1] = !v_q[STAGES-1] | out_ready;
      for (int i = STAGES-2; i >= 0; i--) rdy[i] = !v_q[i] | rdy[i+1];
      src = {v_q[STAGES-2:0], in_valid};
      stage_en = kill ? '0 : rdy & src;
      v_d = kill ? '0 : (rdy & src) | (~rdy & v_q);
   end
   // handshakes and the occupancy / completed-results counters they step
   always_comb begin
      in_ready  = rdy[0] & !kill;
      out_valid = v_q[STAGES-1] & !kill;
      accept    = in_valid & in_ready;
      emit      = out_valid & out_ready;
      occ_d     = kill ? '0 : occ_q + OW'(accept) - OW'(emit);
      done_d    = done_q + CNT_W'(emit);
   end
   // next state: leave IDLE on accept, STALL while the head is back-pressured
   always_comb begin
      state_d = state_q;
      if (kill) state_d = IDLE;
      else case (state_q)
         IDLE:    state_d = accept ? RUN : IDLE;
         RUN:     state_d = (v_q[STAGES-1] & !out_ready) ? STALL : (v_d == '0 ? IDLE : RUN);
         STALL:   state_d = emit ? RUN : STALL;
         default: state_d = IDLE;
      endcase
   end
   // state registers
   always_ff @(posedge clock) begin
      if (reset) begin
         v_q     <= '0;
         occ_q   <= '0;
         done_q  <= '0;
         state_q <= IDLE;
      end else begin
         v_q     <= v_d;
         occ_q   <= occ_d;
         done_q  <= done_d;
         state_q <= state_d;
      end
   end
   // registered status outputs
   always_comb begin
      stage_valid = v_q;
      occupancy   = occ_q;
      done_count  = done_q;
      state       = state_q;
   end
endmodule

// File: tb/tb_sqrt_pipe_ctrl.sv
// tb_sqrt_pipe_ctrl: scoreboard bench with a token-position reference model of the elastic pipe.
module tb_sqrt_pipe_ctrl;
   localparam int S  = 5;
   localparam int CW = 4;
   localparam int OW = $clog2(S+1);
   logic clock = 1'b0;
   logic reset, in_valid, out_ready, in_ready, out_valid;
   logic [S-1:0]  stage_en, stage_valid;
   logic [OW-1:0] occupancy;
   logic [CW-1:0] done_count;
   logic [1:0]    state;
`ifdef SQRT_PIPE_FLUSH_EN
   logic flush = 1'b0;
`endif
   int n_chk = 0, n_fail = 0, cyc = 0, last_lat = -1;
   int pos[$];
   int sb[$];
   int done_m = 0, st_m = 0;

   sqrt_pipe_ctrl #(.STAGES(S), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .stage_en(stage_en),
      .stage_valid(stage_valid), .occupancy(occupancy), .done_count(done_count),
      .state(state)
`ifdef SQRT_PIPE_FLUSH_EN
      , .flush(flush)
`endif
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   // one cycle: drive inputs, compare against the model, then advance the model to the next edge
   task automatic step(input logic rst, input logic iv, input logic ordy, input logic fl);
      int np[$];
      int lim, p;
      logic kill, ov_e, emit_e, ir_e, acc_e;
      logic [S-1:0] sv_e, en_e;
      @(negedge clock);
      reset = rst; in_valid = iv; out_ready = ordy;
`ifdef SQRT_PIPE_FLUSH_EN
      flush = fl;
`endif
      #1;
      kill   = rst | fl;
      ov_e   = !kill && pos.size() > 0 && pos[0] == S-1;
      emit_e = ov_e && ordy;
      ir_e   = !kill && (pos.size() - int'(emit_e)) < S;
      acc_e  = iv && ir_e;
      sv_e = '0;
      foreach (pos[k]) sv_e[pos[k]] = 1'b1;
      en_e = '0;
      for (int k = emit_e ? 1 : 0; k < pos.size(); k++) begin
         lim = np.size() == 0 ? S-1 : np[np.size()-1] - 1;
         p = (pos[k] + 1 <= lim) ? pos[k] + 1 : lim;
         if (p != pos[k] && !kill) en_e[p] = 1'b1;
         np.push_back(p);
      end
      if (acc_e) begin
         en_e[0] = 1'b1;
         np.push_back(0);
         sb.push_back(cyc);
      end
      chk("in_ready", int'(in_ready), int'(ir_e));
      chk("out_valid", int'(out_valid), int'(ov_e));
      chk("stage_en", int'(stage_en), int'(en_e));
      chk("stage_valid", int'(stage_valid), int'(sv_e));
      chk("occupancy", int'(occupancy), pos.size());
      chk("done_count", int'(done_count), done_m);
      chk("state", int'(state), st_m);
      if (rst) begin
         pos.delete(); sb.delete(); done_m = 0; st_m = 0;
      end else if (fl) begin
         pos.delete(); sb.delete(); st_m = 0;
      end else begin
         case (st_m)
            0:       st_m = acc_e ? 1 : 0;
            1:       st_m = (ov_e && !ordy) ? 2 : (np.size() == 0 ? 0 : 1);
            default: st_m = emit_e ? 1 : 2;
         endcase
         pos = np;
         done_m = (done_m + int'(emit_e)) % (1 << CW);
      end
   endtask

   // monitor: each delivered result must retire an outstanding accepted operand, no earlier than the pipe depth
   initial forever begin
      @(negedge clock);
      #3;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) chk("sb_spurious_emit", 1, 0);
         else begin
            last_lat = cyc - sb.pop_front();
            chk("sb_latency_min", int'(last_lat >= S), 1);
         end
      end
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 1, 1, 0);
      repeat (6) step(0, 0, 1, 0);
      chk("t1_latency", last_lat, S);
      repeat (20) step(0, 1, 1, 0);
      repeat (6) step(0, 0, 1, 0);
      chk("t2_latency", last_lat, S);
      repeat (8) step(0, 1, 0, 0);
      repeat (10) step(0, 1, 0, 0);
      repeat (8) step(0, 0, 1, 0);
      for (int i = 0; i < 14; i++) step(0, i % 2 == 0, 0, 0);
      repeat (8) step(0, 0, 1, 0);
      repeat (3) step(0, 1, 0, 0);
      step(1, 1, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
`ifdef SQRT_PIPE_FLUSH_EN
      repeat (7) step(0, 1, 1, 0);
      repeat (6) step(0, 0, 1, 0);
      repeat (4) step(0, 1, 0, 0);
      step(0, 1, 1, 1);
      step(0, 0, 1, 0);
`endif
      for (int i = 0; i < 400; i++) begin
`ifdef SQRT_PIPE_FLUSH_EN
         step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 39) == 0);
`else
         step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, 1'b0);
`endif
      end
      repeat (10) step(0, 0, 1, 0);
      @(negedge clock);
      #5;
      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
